// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with glitch filter, 11-bit frame checks, inter-bit timeout and show-ahead scancode FIFO
// Ports: clk_sys/reset_n (async active-low), ps2_clk_i/ps2_data_i (async PS/2 lines),
//   rd_i pops the head; data_o/valid_o/ext_o/release_o show the head entry;
//   parity_err_o/frame_err_o/overflow_o are one-cycle error pulses.
// Define PS2_PREFIX_DECODE_EN to fold E0/F0 prefixes into ext_o/release_o flags.
`timescale 1ns/1ps
module ps2_kbd_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT = 16383,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  input  logic       rd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       ext_o,
  output logic       release_o,
  output logic       parity_err_o,
  output logic       frame_err_o,
  output logic       overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int EW = 10;
  logic ext, rel;
`else
  localparam int EW = 8;
`endif
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t state;
  logic [1:0] clk_s, dat_s;
  logic fclk, fclk_d, fall, push, pop, full, wr;
  logic [FW-1:0] fcnt;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic par;
  logic [EW-1:0] wdata;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  // fall is the registered view of the filtered clock going 1->0
  assign fall = fclk_d & ~fclk;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      fclk <= 1'b1;
      fclk_d <= 1'b1;
      fcnt <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_i};
      dat_s <= {dat_s[0], ps2_data_i};
      fclk_d <= fclk;
      if (clk_s[1] != fclk) begin
        fcnt <= (fcnt == FW'(FILTER_LEN - 1)) ? '0 : fcnt + 1'b1;
        if (fcnt == FW'(FILTER_LEN - 1)) fclk <= clk_s[1];
      end else
        fcnt <= '0;
    end
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      tcnt <= '0;
      bcnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      push <= 1'b0;
      wdata <= '0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
`ifdef PS2_PREFIX_DECODE_EN
      ext <= 1'b0;
      rel <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            if (!dat_s[1]) begin
              state <= DATA;
              bcnt <= '0;
            end else
              frame_err_o <= 1'b1;
          end
          DATA: begin
            shreg <= {dat_s[1], shreg[7:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par <= dat_s[1];
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // odd parity: data bits plus parity bit must XOR to 1
            if (!dat_s[1] || !(^{shreg, par})) begin
              frame_err_o <= !dat_s[1];
              parity_err_o <= dat_s[1];
`ifdef PS2_PREFIX_DECODE_EN
              ext <= 1'b0;
              rel <= 1'b0;
            end else if (shreg == 8'hE0)
              ext <= 1'b1;
            else if (shreg == 8'hF0)
              rel <= 1'b1;
            else begin
              push <= 1'b1;
              wdata <= {ext, rel, shreg};
              ext <= 1'b0;
              rel <= 1'b0;
            end
`else
            end else begin
              push <= 1'b1;
              wdata <= shreg;
            end
`endif
          end
        endcase
      end else if (state == IDLE)
        tcnt <= '0;
      else if (tcnt == TW'(TIMEOUT - 1)) begin
        state <= IDLE;
        tcnt <= '0;
        frame_err_o <= 1'b1;
`ifdef PS2_PREFIX_DECODE_EN
        ext <= 1'b0;
        rel <= 1'b0;
`endif
      end else
        tcnt <= tcnt + 1'b1;
    end
  assign valid_o = cnt != '0;
  assign pop = rd_i & valid_o;
  assign full = cnt == (AW + 1)'(FIFO_DEPTH);
  // a pop in the same cycle frees the slot, so a push at full still lands
  assign wr = push & (~full | pop);
  always_ff @(posedge clk_sys)
    if (wr) mem[wp] <= wdata;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      overflow_o <= push & full & ~pop;
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW + 1)'(wr) - (AW + 1)'(pop);
    end
  assign data_o = valid_o ? mem[rp][7:0] : 8'h00;
`ifdef PS2_PREFIX_DECODE_EN
  assign ext_o = valid_o & mem[rp][9];
  assign release_o = valid_o & mem[rp][8];
`else
  assign ext_o = 1'b0;
  assign release_o = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: randomized PS/2 frame bench against a queue-based reference model
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
  localparam int H = 40;
  localparam int DEPTH = 8;
  logic clk_sys = 1'b0, reset_n = 1'b0, ps2_clk_i = 1'b1, ps2_data_i = 1'b1, rd_i = 1'b0;
  logic [7:0] data_o;
  logic valid_o, ext_o, release_o, parity_err_o, frame_err_o, overflow_o;
  int vecs = 0, errs = 0;
  int pe_n = 0, fe_n = 0, ov_n = 0, exp_pe = 0, exp_fe = 0, exp_ov = 0;
  int q[$];
  bit m_ext = 0, m_rel = 0;
  always #5 clk_sys = ~clk_sys;
  ps2_kbd_rx dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .rd_i(rd_i), .data_o(data_o), .valid_o(valid_o), .ext_o(ext_o), .release_o(release_o),
    .parity_err_o(parity_err_o), .frame_err_o(frame_err_o), .overflow_o(overflow_o)
  );
  always @(negedge clk_sys) begin
    pe_n += int'(parity_err_o);
    fe_n += int'(frame_err_o);
    ov_n += int'(overflow_o);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic m_put(input int e);
    if (q.size() < DEPTH) q.push_back(e);
    else exp_ov++;
  endtask
  task automatic m_frame(input logic [7:0] b, input bit bp, input bit bs, input bit pop);
    if (pop && q.size() != 0) void'(q.pop_front());
    if (bs || bp) begin
      if (bs) exp_fe++;
      else exp_pe++;
      m_ext = 0;
      m_rel = 0;
    end else begin
`ifdef PS2_PREFIX_DECODE_EN
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
        m_put({22'd0, m_ext, m_rel, b});
        m_ext = 0;
        m_rel = 0;
      end
`else
      m_put({24'd0, b});
`endif
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bp, input bit bs, input int n, input bit pop);
    logic [10:0] f;
    f = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys) ps2_data_i = f[i];
      repeat (H) @(negedge clk_sys);
      ps2_clk_i = 1'b0;
      if (pop && i == 10) begin
        repeat (11) @(negedge clk_sys);
        rd_i = 1'b1;
        @(negedge clk_sys) rd_i = 1'b0;
        repeat (H - 12) @(negedge clk_sys);
      end else
        repeat (H) @(negedge clk_sys);
      ps2_clk_i = 1'b1;
    end
    ps2_data_i = 1'b1;
  endtask
  task automatic check_state(input string tag);
    chk({tag, ".perr"}, pe_n, exp_pe);
    chk({tag, ".ferr"}, fe_n, exp_fe);
    chk({tag, ".ovf"}, ov_n, exp_ov);
    chk({tag, ".valid"}, valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk({tag, ".data"}, data_o, q[0][7:0]);
      chk({tag, ".ext"}, ext_o, q[0][9]);
      chk({tag, ".rel"}, release_o, q[0][8]);
    end
  endtask
  task automatic frame(input logic [7:0] b, input bit bp, input bit bs, input bit pop);
    send(b, bp, bs, 11, pop);
    m_frame(b, bp, bs, pop);
    repeat (30) @(negedge clk_sys);
    check_state("frame");
  endtask
  task automatic pop_one();
    @(negedge clk_sys) rd_i = 1'b1;
    @(negedge clk_sys) rd_i = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
    repeat (2) @(negedge clk_sys);
    check_state("pop");
  endtask
  task automatic drain();
    while (q.size() != 0) pop_one();
    chk("drain.empty", valid_o, 1'b0);
  endtask
  initial begin
    repeat (5) @(negedge clk_sys);
    chk("rst.valid", valid_o, 1'b0);
    chk("rst.data", data_o, 8'h00);
    chk("rst.flags", {ext_o, release_o, parity_err_o, frame_err_o, overflow_o}, 5'b0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    frame(8'h1C, 0, 0, 0);
    pop_one();
    frame(8'h5A, 1, 0, 0);
    frame(8'h5A, 0, 1, 0);
    send(8'h1C, 0, 0, 5, 0);
    repeat (17000) @(negedge clk_sys);
    exp_fe++;
    m_ext = 0;
    m_rel = 0;
    check_state("timeout");
    frame(8'h1C, 0, 0, 0);
    drain();
    for (int i = 1; i <= 9; i++) frame(8'(i), 0, 0, 0);
    frame(8'h0A, 0, 0, 1);
    drain();
    repeat (5) begin
      @(negedge clk_sys) ps2_clk_i = 1'b0;
      repeat (3) @(negedge clk_sys);
      ps2_clk_i = 1'b1;
      repeat (20) @(negedge clk_sys);
    end
    check_state("glitch");
    frame(8'h29, 0, 0, 0);
    send(8'h33, 0, 0, 4, 0);
    reset_n = 1'b0;
    q.delete();
    m_ext = 0;
    m_rel = 0;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2 * H) @(negedge clk_sys);
    check_state("midrst");
    frame(8'h45, 0, 0, 0);
    drain();
    frame(8'hE0, 0, 0, 0);
    frame(8'hF0, 0, 0, 0);
    frame(8'h75, 0, 0, 0);
    drain();
    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      b = (r == 2) ? 8'hE0 : (r == 3) ? 8'hF0 : 8'($urandom);
      frame(b, r == 0, r == 1, 0);
      if ($urandom_range(0, 2) == 0) pop_one();
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
